keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 active-low key matrix, debounces press and release, and encodes the key.
//   Drives the calculator FSM's key input: key_code feeds `in`, pressed feeds `pressed`.
//   The FSM acts on the falling edge of pressed, so pressed is a clean debounced level.
//   pressed is high while the key is held; key_code is stable for its whole high time.
// PARAMETERS
//   SCAN_DIV      1000  clk cycles per scan tick (row dwell); must be >= 4
//   DEBOUNCE_CNT  8     consecutive identical tick samples to accept a press or a release (>= 2)
//   REPEAT_DLY    200   ticks held before the first auto-repeat (KEY_REPEAT_EN only)
//   REPEAT_RATE   50    ticks between auto-repeats (KEY_REPEAT_EN only)
// PORTS
//   clk        in   1  system clock
//   rst        in   1  reset, asynchronous, active-high
//   col        in   4  matrix columns, active-low, pulled up; asynchronous to clk
//   row        out  4  matrix row drive, active-low one-hot
//   key_code   out  8  encoded key; upper nibble 0
//   pressed    out  1  debounced key-held level
//   key_valid  out  1  one-clk pulse when a new key is accepted
// BEHAVIOUR
//   Reset values
//   - row=4'b1110, key_code=8'h00, pressed=0, key_valid=0.
//   - State SCAN; tick divider, debounce counter and repeat counter all 0.
//   Input sampling
//   - col passes a 2-flop synchronizer; all decisions use the synchronized value (colS).
//   - tick: 1-clk strobe when divider == SCAN_DIV-1; divider then wraps to 0.
//   - Samples are taken only on tick.
//   Key map (row r = row driven low, c = col index)
//   - r0: 1 2 3 +(0A)   r1: 4 5 6 -(0B)   r2: 7 8 9 *(0C)   r3: C(0F) 0 =(0E) /(0D)
//   - Digits encode as 8'h00..8'h09.
//   - Valid sample: exactly one colS bit low.
//   - Two or more bits low (ghost/multi-key) are treated as no key.
//   FSM states: SCAN, DEBOUNCE, HELD, RELEASE
//   - SCAN: on tick, a valid sample captures the column and goes to DEBOUNCE with cnt=1;
//     row stays put. Otherwise rotate row (1110->1101->1011->0111->1110).
//   - DEBOUNCE: row frozen. On tick, a sample matching the captured column increments cnt.
//     When cnt reaches DEBOUNCE_CNT: key_code<=encoded key, pressed<=1, key_valid<=1
//     (same edge), cnt<=0, go to HELD.
//     Any mismatch or invalid sample: cnt<=0, back to SCAN; row resumes rotating next tick.
//   - HELD: on tick, colS==4'hF goes to RELEASE with cnt=1; any other pattern is ignored.
//     A second key pressed while holding is not reported.
//   - RELEASE: on tick, colS==4'hF increments cnt. When cnt reaches DEBOUNCE_CNT:
//     pressed<=0, go to SCAN. Any low bit: back to HELD, cnt<=0, pressed stays 1.
//   - key_code keeps its last value after release until the next accepted key.
//   - key_valid is high for exactly 1 clk per accepted key.
//   Reset mid-operation
//   - Asserting rst in any state forces all reset values immediately (asynchronous).
//   - A key still held after rst deasserts must be debounced afresh before it is reported.
//   Latency
//   - Press: pressed rises on the DEBOUNCE_CNT-th consecutive matching tick, counting the
//     SCAN detection tick; plus 2-clk synchronizer delay from col.
//   - Release: pressed falls on the DEBOUNCE_CNT-th consecutive all-high tick.
// CONFIGURATION
//   KEY_REPEAT_EN defined
//   - In HELD, count ticks. After REPEAT_DLY ticks, pulse key_valid, then pulse again every
//     REPEAT_RATE ticks while held.
//   - pressed stays high; key_code is unchanged; the repeat counter clears on leaving HELD.
//   KEY_REPEAT_EN undefined
//   - key_valid pulses once per press; REPEAT_* parameters are unused.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DLY=5, REPEAT_RATE=2)
//   1 Reset -> row=1110, key_code=00, pressed=0; row rotates once every 4 clk.
//   2 Hold col=1101 while row=1011 for 20 clk -> key_code=08, pressed=1, 1-clk key_valid;
//     row frozen at 1011.
//   3 Release from test 2 -> pressed falls after 3 all-high ticks; key_code stays 08.
//     The FSM sees exactly one negedge.
//   4 Bounce: col=0111 on row 0111 for 1 tick, high 1 tick, repeat -> no pressed, no key_valid.
//   5 col=1100 (two columns low) on any row -> no key reported; scan continues.
//   6 rst pulsed while HELD -> pressed=0 and row=1110 immediately.
//     With KEY_REPEAT_EN: key '=' held 12 ticks -> key_valid pulses at press, then ticks 5, 7, 9, 11.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad matrix bus between the scanner and the key matrix / key consumer.
//   col       matrix columns, active-low, pulled up (driven by the matrix)
//   row       row drive, active-low one-hot (driven by the scanner)
//   key_code  encoded key, upper nibble 0
//   pressed   debounced key-held level
//   key_valid one-clk pulse per accepted key (and per auto-repeat when enabled)
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] key_code;
  logic       pressed;
  logic       key_valid;

  modport master (input col, output row, key_code, pressed, key_valid);
  modport slave  (output col, input row, key_code, pressed, key_valid);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and key encoding.
//   clk  system clock
//   rst  asynchronous, active-high reset
//   kp   keypad_scanner_if.master: col in; row, key_code, pressed, key_valid out
// Optional feature: define KEY_REPEAT_EN to get auto-repeat key_valid pulses
// while a key is held (first after REPEAT_DLY ticks, then every REPEAT_RATE ticks).
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned REPEAT_DLY   = 200,
  parameter int unsigned REPEAT_RATE  = 50
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

  // Reject parameter sets the scan/debounce/repeat logic cannot honour.
  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter set");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state_q;
  logic [3:0]       col_meta_q;
  logic [3:0]       col_s;
  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [3:0]       cap_col_q;
  logic [3:0]       row_q;
  logic [7:0]       key_code_q;
  logic             pressed_q;
  logic             key_valid_q;
  logic             sample_ok_c;
  logic [1:0]       col_idx_c;
  logic [1:0]       row_idx_c;

  assign kp.row       = row_q;
  assign kp.key_code  = key_code_q;
  assign kp.pressed   = pressed_q;
  assign kp.key_valid = key_valid_q;

  // Two-flop synchronizer; idles at all-high (released) like the pulled-up matrix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s      <= 4'hF;
    end else begin
      col_meta_q <= kp.col;
      col_s      <= col_meta_q;
    end
  end

  // Scan tick divider.
  assign tick_c = (div_q == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Exactly one low column is a usable sample; anything else counts as no key.
  always_comb begin
    sample_ok_c = 1'b1;
    col_idx_c   = 2'd0;
    case (col_s)
      4'b1110: col_idx_c = 2'd0;
      4'b1101: col_idx_c = 2'd1;
      4'b1011: col_idx_c = 2'd2;
      4'b0111: col_idx_c = 2'd3;
      default: sample_ok_c = 1'b0;
    endcase
  end

  always_comb begin
    row_idx_c = 2'd0;
    case (row_q)
      4'b1101: row_idx_c = 2'd1;
      4'b1011: row_idx_c = 2'd2;
      4'b0111: row_idx_c = 2'd3;
      default: row_idx_c = 2'd0;
    endcase
  end

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Calculator key map: digits 0-9, + - * / = C as 0A 0B 0C 0D 0E 0F.
  function automatic logic [7:0] encode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hF;
      4'hD: k = 4'h0;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return {4'h0, k};
  endfunction

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_inc_c;
  logic [RPT_W-1:0] rpt_thr_c;
  logic             rpt_armed_q;

  // First repeat waits REPEAT_DLY ticks, later ones REPEAT_RATE ticks.
  assign rpt_inc_c = rpt_cnt_q + RPT_W'(1);
  assign rpt_thr_c = rpt_armed_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DLY);
`endif

  // Scan / debounce FSM; all decisions happen on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      row_q       <= 4'b1110;
      key_code_q  <= 8'h00;
      pressed_q   <= 1'b0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
      cap_col_q   <= 4'hF;
`ifdef KEY_REPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (tick_c) begin
        case (state_q)
          SCAN: begin
            if (sample_ok_c) begin
              cap_col_q <= col_s;
              cnt_q     <= CNT_W'(1);
              state_q   <= DEBOUNCE;
            end else begin
              row_q <= {row_q[2:0], row_q[3]};
            end
          end
          DEBOUNCE: begin
            if (col_s == cap_col_q) begin
              if (cnt_inc_c == CNT_W'(DEBOUNCE_CNT)) begin
                key_code_q  <= encode_key(row_idx_c, col_idx_c);
                pressed_q   <= 1'b1;
                key_valid_q <= 1'b1;
                cnt_q       <= '0;
                state_q     <= HELD;
              end else begin
                cnt_q <= cnt_inc_c;
              end
            end else begin
              // Row is not rotated on this tick; scanning resumes on the next one.
              cnt_q   <= '0;
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (col_s == 4'hF) begin
              cnt_q   <= CNT_W'(1);
              state_q <= RELEASE;
`ifdef KEY_REPEAT_EN
              rpt_cnt_q   <= '0;
              rpt_armed_q <= 1'b0;
            end else if (rpt_inc_c == rpt_thr_c) begin
              key_valid_q <= 1'b1;
              rpt_cnt_q   <= '0;
              rpt_armed_q <= 1'b1;
            end else begin
              rpt_cnt_q <= rpt_inc_c;
            end
`else
            end
`endif
          end
          RELEASE: begin
            if (col_s == 4'hF) begin
              if (cnt_inc_c == CNT_W'(DEBOUNCE_CNT)) begin
                pressed_q <= 1'b0;
                cnt_q     <= '0;
                state_q   <= SCAN;
              end else begin
                cnt_q <= cnt_inc_c;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix drives col from row,
// expected key_valid payloads are queued by the stimulus and checked by a
// negedge monitor.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 3;
  localparam int unsigned REPEAT_DLY   = 5;
  localparam int unsigned REPEAT_RATE  = 2;

  logic clk = 1'b0;
  logic rst;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  // Key matrix model: a held key pulls its column low while its row is driven.
  logic       key_down;
  logic [1:0] key_r;
  logic [1:0] key_c;
  logic       direct_en;
  logic [3:0] direct_val;

  always_comb begin
    kp.col = 4'hF;
    if (direct_en) kp.col = direct_val;
    else if (key_down && kp.row == ~(4'b0001 << key_r)) kp.col[key_c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic prev_valid   = 1'b0;
  logic prev_pressed = 1'b0;
  int   fall_cnt = 0;
  int   rise_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h @%0t", name, got, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key_valid got key_code=%0h required no pulse @%0t", kp.key_code, $time);
      end else begin
        exp_v = exp_q.pop_front();
        check("kv_key_code", 32'(kp.key_code), 32'(exp_v));
        check("kv_pressed", 32'(kp.pressed), 32'd1);
      end
      check("kv_one_clk", 32'(prev_valid), 32'd0);
    end
    if (prev_pressed && !kp.pressed) fall_cnt++;
    if (!prev_pressed && kp.pressed) rise_cnt++;
    prev_valid   = kp.key_valid;
    prev_pressed = kp.pressed;
  end

  task automatic wait_pressed(input logic lvl, input int max_cyc, output int n);
    n = 0;
    while (kp.pressed !== lvl && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;
  int row_changes;
  int rise_before;
  logic [3:0] last_row;

  initial begin
    rst        = 1'b1;
    key_down   = 1'b0;
    key_r      = 2'd0;
    key_c      = 2'd0;
    direct_en  = 1'b0;
    direct_val = 4'hF;

    // 1: reset values and row rotation every SCAN_DIV clocks
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", 32'(kp.row), 32'hE);
    check("rst_key_code", 32'(kp.key_code), 32'h0);
    check("rst_pressed", 32'(kp.pressed), 32'd0);
    check("rst_key_valid", 32'(kp.key_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rot_hold", 32'(kp.row), 32'hE);
    @(posedge clk); #1;
    check("rot_1", 32'(kp.row), 32'hD);
    repeat (4) @(posedge clk); #1;
    check("rot_2", 32'(kp.row), 32'hB);
    repeat (4) @(posedge clk); #1;
    check("rot_3", 32'(kp.row), 32'h7);
    repeat (4) @(posedge clk); #1;
    check("rot_wrap", 32'(kp.row), 32'hE);

    // 2: key '8' (row 2, col 1)
    exp_q.push_back(8'h08);
    key_r = 2'd2; key_c = 2'd1; key_down = 1'b1;
    wait_pressed(1'b1, 200, n);
    check("press8_pressed", 32'(kp.pressed), 32'd1);
    check("press8_code", 32'(kp.key_code), 32'h08);
    check("press8_row", 32'(kp.row), 32'hB);
    repeat (20) @(posedge clk);
    #1;
    check("held8_row_frozen", 32'(kp.row), 32'hB);
    check("held8_pressed", 32'(kp.pressed), 32'd1);

    // 3: release, pressed falls on the third all-high tick
    key_down = 1'b0;
    wait_pressed(1'b0, 100, n);
    check("rel8_pressed", 32'(kp.pressed), 32'd0);
    check("rel8_latency_11_14", 32'(n >= 11 && n <= 14), 32'd1);
    check("rel8_code_kept", 32'(kp.key_code), 32'h08);
    @(negedge clk); #1;
    check("rel8_one_negedge", 32'(fall_cnt), 32'd1);

    // 4: bouncing '/' (row 3, col 3): alternate every tick, never accepted
    rise_before = rise_cnt;
    key_r = 2'd3; key_c = 2'd3;
    for (int i = 0; i < 10; i++) begin
      key_down = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      key_down = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;
    check("bounce_pressed", 32'(kp.pressed), 32'd0);
    check("bounce_no_rise", 32'(rise_cnt), 32'(rise_before));

    // 5: two columns low is ignored and scanning continues
    direct_en = 1'b1; direct_val = 4'b1100;
    row_changes = 0;
    last_row = kp.row;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (kp.row !== last_row) row_changes++;
      last_row = kp.row;
    end
    check("ghost_row_rotations", 32'(row_changes), 32'd10);
    check("ghost_pressed", 32'(kp.pressed), 32'd0);
    direct_en = 1'b0;

    // 6: key '=' (row 3, col 2) held, then reset while HELD
    exp_q.push_back(8'h0E);
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h0E);
`endif
    key_r = 2'd3; key_c = 2'd2; key_down = 1'b1;
    wait_pressed(1'b1, 200, n);
    check("pressEq_pressed", 32'(kp.pressed), 32'd1);
    check("pressEq_code", 32'(kp.key_code), 32'h0E);
    repeat (46) @(posedge clk);
    #1;
    check("heldEq_pressed", 32'(kp.pressed), 32'd1);
    check("heldEq_row", 32'(kp.row), 32'h7);
    check("heldEq_pulses_seen", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_pressed", 32'(kp.pressed), 32'd0);
    check("async_rst_row", 32'(kp.row), 32'hE);
    check("async_rst_code", 32'(kp.key_code), 32'h0);
    check("async_rst_valid", 32'(kp.key_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Still-held key must be debounced again after reset
    exp_q.push_back(8'h0E);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_not_yet", 32'(kp.pressed), 32'd0);
    wait_pressed(1'b1, 200, n);
    check("post_rst_pressed", 32'(kp.pressed), 32'd1);
    check("post_rst_code", 32'(kp.key_code), 32'h0E);
    key_down = 1'b0;
    wait_pressed(1'b0, 100, n);
    check("post_rst_released", 32'(kp.pressed), 32'd0);
    @(negedge clk); #1;
    check("total_negedges", 32'(fall_cnt), 32'd3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
